// File: rtl/apb_req_sched.sv
// Round-robin scheduler sharing one APB master port between NUM_REQ requesters.
// Sequences SETUP/ACCESS, bounds ACCESS with a PREADY timeout, returns a one-cycle response pulse.
module apb_req_sched #(
    parameter int NUM_REQ        = 2,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    output logic [NUM_REQ-1:0]                 req_ready_o,
    input  logic [NUM_REQ-1:0]                 req_write_i,
    input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0]  req_addr_i,
    input  logic [NUM_REQ*APB_DATA_WIDTH-1:0]  req_wdata_i,
    output logic [NUM_REQ-1:0]                 rsp_valid_o,
    output logic [APB_DATA_WIDTH-1:0]          rsp_rdata_o,
    output logic                               rsp_err_o,
    output logic [APB_ADDR_WIDTH-1:0]          paddr_o,
    output logic [APB_DATA_WIDTH-1:0]          pwdata_o,
    output logic                               pwrite_o,
    output logic                               psel_o,
    output logic                               penable_o,
    input  logic [APB_DATA_WIDTH-1:0]          prdata_i,
    input  logic                               pready_i,
    input  logic                               pslverr_i
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    // cnt_r counts completed ACCESS cycles, so the N-th cycle sees N-1
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : {CW{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                     state_r;
    state_t                     state_s;
    logic [GW-1:0]              last_grant_r;
    logic [GW-1:0]              grant_r;
    logic [GW-1:0]              win_s;
    logic                       found_s;
    int                         idx_s;
    logic                       any_valid_s;
    logic                       accept_s;
    logic                       timeout_s;
    logic                       done_s;
    logic [CW-1:0]              cnt_r;
    logic [APB_ADDR_WIDTH-1:0]  paddr_r;
    logic [APB_DATA_WIDTH-1:0]  pwdata_r;
    logic                       pwrite_r;
    logic [NUM_REQ-1:0]         rsp_valid_r;
    logic [APB_DATA_WIDTH-1:0]  rsp_rdata_r;
    logic                       rsp_err_r;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [GW-1:0] idx);
        onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    assign any_valid_s = |req_valid_i;
    assign accept_s    = (state_r == ST_IDLE) && any_valid_s;
    assign timeout_s   = TO_EN && (cnt_r == TO_LAST);
    assign done_s      = pready_i || timeout_s;

    // Round-robin winner: first valid requester after last_grant_r, wrapping.
    always_comb begin
        win_s   = last_grant_r;
        found_s = 1'b0;
        idx_s   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_s = (int'(last_grant_r) + k) % NUM_REQ;
            if (!found_s && req_valid_i[idx_s]) begin
                win_s   = GW'(idx_s);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:   state_s = any_valid_s ? ST_SETUP : ST_IDLE;
            ST_SETUP:  state_s = ST_ACCESS;
            ST_ACCESS: state_s = done_s ? ST_IDLE : ST_ACCESS;
            default:   state_s = ST_IDLE;
        endcase
    end

    // FSM outputs: APB strobes and the IDLE-only accept.
    always_comb begin
        psel_o      = 1'b0;
        penable_o   = 1'b0;
        req_ready_o = {NUM_REQ{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (any_valid_s) begin
                    req_ready_o = onehot(win_s);
                end else begin
                    req_ready_o = {NUM_REQ{1'b0}};
                end
            end
            ST_SETUP: begin
                psel_o = 1'b1;
            end
            ST_ACCESS: begin
                psel_o    = 1'b1;
                penable_o = 1'b1;
            end
            default: begin
                psel_o    = 1'b0;
                penable_o = 1'b0;
            end
        endcase
    end

    // Latch the accepted request and run the ACCESS cycle counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant_r <= GW'(NUM_REQ - 1);
            grant_r      <= {GW{1'b0}};
            paddr_r      <= {APB_ADDR_WIDTH{1'b0}};
            pwdata_r     <= {APB_DATA_WIDTH{1'b0}};
            pwrite_r     <= 1'b0;
            cnt_r        <= {CW{1'b0}};
        end else if (accept_s) begin
            last_grant_r <= win_s;
            grant_r      <= win_s;
            paddr_r      <= req_addr_i[int'(win_s)*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
            pwdata_r     <= req_wdata_i[int'(win_s)*APB_DATA_WIDTH +: APB_DATA_WIDTH];
            pwrite_r     <= req_write_i[win_s];
            cnt_r        <= {CW{1'b0}};
        end else if (state_r == ST_ACCESS) begin
            cnt_r        <= cnt_r + CW'(1);
        end
    end

    // Completion: pulse the granted requester and update the held read data / error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_valid_r <= {NUM_REQ{1'b0}};
            rsp_rdata_r <= {APB_DATA_WIDTH{1'b0}};
            rsp_err_r   <= 1'b0;
        end else begin
            rsp_valid_r <= {NUM_REQ{1'b0}};
            if (state_r == ST_ACCESS) begin
                if (pready_i) begin
                    if (!pwrite_r) begin
                        rsp_rdata_r <= prdata_i;
                    end
                    rsp_err_r   <= pslverr_i;
                    rsp_valid_r <= onehot(grant_r);
                end else if (timeout_s) begin
                    rsp_rdata_r <= {APB_DATA_WIDTH{1'b0}};
                    rsp_err_r   <= 1'b1;
                    rsp_valid_r <= onehot(grant_r);
                end
            end
        end
    end

    assign paddr_o     = paddr_r;
    assign pwdata_o    = pwdata_r;
    assign pwrite_o    = pwrite_r;
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_rdata_o = rsp_rdata_r;
    assign rsp_err_o   = rsp_err_r;

endmodule

// File: tb/tb_apb_req_sched.sv
// Self-checking bench for apb_req_sched: per-requester drivers, a simple APB slave,
// and scoreboards for the APB side and the response side.
module tb_apb_req_sched;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [NR-1:0]    req_valid_i;
    logic [NR-1:0]    req_ready_o;
    logic [NR-1:0]    req_write_i;
    logic [NR*AW-1:0] req_addr_i;
    logic [NR*DW-1:0] req_wdata_i;
    logic [NR-1:0]    rsp_valid_o;
    logic [DW-1:0]    rsp_rdata_o;
    logic             rsp_err_o;
    logic [AW-1:0]    paddr_o;
    logic [DW-1:0]    pwdata_o;
    logic             pwrite_o;
    logic             psel_o;
    logic             penable_o;
    logic [DW-1:0]    prdata_i;
    logic             pready_i;
    logic             pslverr_i;

    apb_req_sched #(
        .NUM_REQ(NR), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pwrite_o(pwrite_o),
        .psel_o(psel_o), .penable_o(penable_o),
        .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          req;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } tx_t;

    tx_t pend0[$];
    tx_t pend1[$];
    tx_t exp_q[$];
    tx_t apb_q[$];
    int  acc_q[$];
    int  grant_log[$];
    int  acc_log[$];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          last_acc_cyc = 0;
    logic [31:0] model_rdata;
    logic        pen_prev = 1'b0;

    // APB slave: PREADY after slv_wait wait states, or never when stuck
    int          slv_wait  = 0;
    bit          slv_stuck = 1'b0;
    bit          slv_err   = 1'b0;
    logic [31:0] slv_rdata = 32'h0;
    logic [7:0]  acc_cnt   = 8'd0;

    assign pready_i  = psel_o & penable_o & ~slv_stuck & (int'(acc_cnt) == slv_wait);
    assign prdata_i  = slv_rdata;
    assign pslverr_i = slv_err & pready_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(posedge clk_i) begin
        if (psel_o && penable_o && !pready_i) acc_cnt <= acc_cnt + 8'd1;
        else                                  acc_cnt <= 8'd0;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue one transaction; expected response uses the current slave settings.
    task automatic add(input int req, input logic write, input logic [31:0] addr,
                       input logic [31:0] wdata, input int lat, input bit expect_rsp);
        tx_t t;
        t.req = req; t.addr = addr; t.wdata = wdata; t.write = write; t.lat = lat;
        t.rdata = 32'h0; t.err = 1'b0;
        if (expect_rsp) begin
            if (slv_stuck) begin
                model_rdata = 32'h0;
                t.err       = 1'b1;
            end else begin
                if (!write) model_rdata = slv_rdata;
                t.err = slv_err;
            end
            t.rdata = model_rdata;
            exp_q.push_back(t);
        end
        apb_q.push_back(t);
        if (req == 0) pend0.push_back(t);
        else          pend1.push_back(t);
    endtask

    // Present queued requests until all are accepted (bounded).
    task automatic drive(input int max_cyc);
        logic [NR-1:0] rdy;
        int n = 0;
        while ((pend0.size() > 0 || pend1.size() > 0) && n < max_cyc) begin
            req_valid_i = {pend1.size() > 0, pend0.size() > 0};
            if (pend0.size() > 0) begin
                req_addr_i[31:0]  = pend0[0].addr;
                req_wdata_i[31:0] = pend0[0].wdata;
                req_write_i[0]    = pend0[0].write;
            end
            if (pend1.size() > 0) begin
                req_addr_i[63:32]  = pend1[0].addr;
                req_wdata_i[63:32] = pend1[0].wdata;
                req_write_i[1]     = pend1[0].write;
            end
            @(negedge clk_i);
            rdy = req_ready_o;
            check_eq("ready_onehot", 64'($onehot0(rdy)), 64'd1);
            if (rdy != 2'b00) begin
                grant_log.push_back(rdy[1] ? 1 : 0);
                acc_log.push_back(cyc);
                acc_q.push_back(cyc);
                last_acc_cyc = cyc;
            end
            @(posedge clk_i); #1;
            if (rdy[0] && pend0.size() > 0) void'(pend0.pop_front());
            if (rdy[1] && pend1.size() > 0) void'(pend1.pop_front());
            n++;
        end
        req_valid_i = 2'b00;
        check_eq("drive_done", 64'(pend0.size() + pend1.size()), 64'd0);
    endtask

    task automatic wait_drain(input int max_cyc);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(posedge clk_i); #1;
            n++;
        end
        check_eq("rsp_drain", 64'(exp_q.size()), 64'd0);
        repeat (2) begin @(posedge clk_i); #1; end
    endtask

    // APB-side monitor: phase timing and latched address/data
    always @(negedge clk_i) begin
        if (psel_o && !penable_o) begin
            check_eq("setup_lat", 64'(cyc - last_acc_cyc), 64'd1);
            if (apb_q.size() == 0) begin
                check_eq("apb_unexpected", 64'(psel_o), 64'd0);
            end else begin
                check_eq("paddr", 64'(paddr_o), 64'(apb_q[0].addr));
                check_eq("pwrite", 64'(pwrite_o), 64'(apb_q[0].write));
                if (apb_q[0].write) check_eq("pwdata", 64'(pwdata_o), 64'(apb_q[0].wdata));
                void'(apb_q.pop_front());
            end
        end
        if (psel_o && penable_o && !pen_prev)
            check_eq("access_lat", 64'(cyc - last_acc_cyc), 64'd2);
        pen_prev <= penable_o;
    end

    // Response monitor: pops the scoreboard on every pulse
    always @(negedge clk_i) begin
        if (rsp_valid_o != 2'b00) begin
            if (exp_q.size() == 0) begin
                check_eq("rsp_unexpected", 64'(rsp_valid_o), 64'd0);
            end else begin
                check_eq("rsp_req", 64'(rsp_valid_o), 64'd1 << exp_q[0].req);
                check_eq("rsp_err", 64'(rsp_err_o), 64'(exp_q[0].err));
                check_eq("rsp_rdata", 64'(rsp_rdata_o), 64'(exp_q[0].rdata));
                check_eq("rsp_lat", 64'((acc_q.size() > 0) ? cyc - acc_q[0] : -1), 64'(exp_q[0].lat));
                check_eq("psel_at_rsp", 64'(psel_o), 64'd0);
                void'(exp_q.pop_front());
                if (acc_q.size() > 0) void'(acc_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 1'b1; req_valid_i = 2'b00; req_write_i = 2'b00;
        req_addr_i = '0; req_wdata_i = '0; model_rdata = 32'h0;
        repeat (2) @(posedge clk_i);
        #1;
        check_eq("rst_psel", 64'(psel_o), 64'd0);
        check_eq("rst_penable", 64'(penable_o), 64'd0);
        check_eq("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check_eq("rst_rsp_err", 64'(rsp_err_o), 64'd0);
        check_eq("rst_rsp_rdata", 64'(rsp_rdata_o), 64'd0);
        check_eq("rst_paddr", 64'(paddr_o), 64'd0);
        check_eq("rst_pwdata", 64'(pwdata_o), 64'd0);
        check_eq("rst_pwrite", 64'(pwrite_o), 64'd0);
        check_eq("rst_ready", 64'(req_ready_o), 64'd0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // single write, zero wait
        slv_wait = 0; slv_stuck = 1'b0; slv_err = 1'b0; slv_rdata = 32'h0BAD_0BAD;
        add(0, 1'b1, 32'h1A10_0004, 32'hDEAD_BEEF, 3, 1'b1);
        drive(20); wait_drain(20);

        // read with 3 wait states (PREADY lands in the 4th ACCESS cycle)
        slv_wait = 3; slv_rdata = 32'h1234_5678;
        add(1, 1'b0, 32'h1A10_0008, 32'h0, 6, 1'b1);
        drive(20); wait_drain(20);

        // round-robin fairness, both requesters valid throughout
        slv_wait = 0; slv_rdata = 32'hA5A5_0001;
        grant_log.delete(); acc_log.delete();
        add(0, 1'b1, 32'h1A10_0100, 32'h0000_0A00, 3, 1'b1);
        add(1, 1'b0, 32'h1A10_0104, 32'h0, 3, 1'b1);
        add(0, 1'b0, 32'h1A10_0108, 32'h0, 3, 1'b1);
        add(1, 1'b1, 32'h1A10_010C, 32'h0000_0B01, 3, 1'b1);
        drive(40); wait_drain(40);
        check_eq("rr_count", 64'(grant_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            check_eq("rr_order", 64'(grant_log[i]), 64'(i % 2));
        for (int i = 0; i < 3 && i + 1 < acc_log.size(); i++)
            check_eq("rr_spacing", 64'(acc_log[i+1] - acc_log[i]), 64'd3);

        // timeout with PREADY stuck low
        slv_stuck = 1'b1;
        add(0, 1'b1, 32'h1A10_0010, 32'h1111_2222, 2 + TO, 1'b1);
        drive(20); wait_drain(30);

        // PREADY in exactly the last allowed cycle wins over the timeout
        slv_stuck = 1'b0; slv_wait = TO - 1; slv_rdata = 32'hCAFE_0001;
        add(1, 1'b0, 32'h1A10_0014, 32'h0, 2 + TO, 1'b1);
        drive(20); wait_drain(30);

        // PSLVERR on requester 1
        slv_wait = 0; slv_err = 1'b1; slv_rdata = 32'h55AA_55AA;
        add(1, 1'b0, 32'h1A10_0018, 32'h0, 3, 1'b1);
        drive(20); wait_drain(20);

        // reset during an ACCESS wait state
        slv_err = 1'b0; slv_stuck = 1'b1;
        add(0, 1'b1, 32'h1A10_0020, 32'h7777_7777, 0, 1'b0);
        drive(20);
        repeat (3) @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        check_eq("mid_rst_psel", 64'(psel_o), 64'd0);
        check_eq("mid_rst_penable", 64'(penable_o), 64'd0);
        check_eq("mid_rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check_eq("mid_rst_rsp_err", 64'(rsp_err_o), 64'd0);
        check_eq("mid_rst_rsp_rdata", 64'(rsp_rdata_o), 64'd0);
        check_eq("mid_rst_paddr", 64'(paddr_o), 64'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        acc_q.delete();
        model_rdata = 32'h0;
        slv_stuck = 1'b0; slv_wait = 0; slv_rdata = 32'h0F0F_0F0F;
        repeat (6) begin @(posedge clk_i); #1; end
        grant_log.delete();
        add(0, 1'b0, 32'h1A10_0030, 32'h0, 3, 1'b1);
        add(1, 1'b0, 32'h1A10_0034, 32'h0, 3, 1'b1);
        drive(30); wait_drain(30);
        check_eq("post_rst_count", 64'(grant_log.size()), 64'd2);
        if (grant_log.size() > 1) begin
            check_eq("post_rst_first", 64'(grant_log[0]), 64'd0);
            check_eq("post_rst_second", 64'(grant_log[1]), 64'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
